// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the six-digit seven-segment display path.
// Used by seg_disp_arbiter and available to data_gen / seg_595_dynamic so
// all producers agree on the digit bundle widths.
//   DATA_W  : packed BCD digits (6 digits x 4 bits, minus the top nibble = 20)
//   POINT_W : decimal-point mask, one bit per digit
package seg_pkg;

  localparam int DATA_W  = 20;
  localparam int POINT_W = 6;

  // Arbiter ownership states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    SHARE = 2'd2,
    GAP   = 2'd3
  } arb_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_disp_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Searches req_i starting one above ptr_i, wrapping modulo N_REQ, so the
// requester at ptr_i itself is considered last.
//   req_i : request vector
//   ptr_i : index of the last owner
//   win_o : one-hot winner (all-zero when nothing requests)
//   vld_o : a winner exists
module rr_pick
  #(parameter int N_REQ = 3,
    parameter int PTR_W = 2)
  (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_o,
  output logic             vld_o
  );

  always_comb begin
    int idx;
    idx   = 0;
    win_o = '0;
    vld_o = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(ptr_i) + off) % N_REQ;
      if (!vld_o && req_i[idx]) begin
        win_o[idx] = 1'b1;
        vld_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: time-shares the seven-segment display among N_REQ
// content producers. Round-robin ownership with a minimum dwell of
// HOLD_CYC clocks and an optional GAP_CYC-clock blank between owners.
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   req              : per-requester level request
//   req_data/point/sign : packed per-requester display content
//   grant            : one-hot current owner (registered)
//   data/point/sign/seg_en : registered bundle to seg_595_dynamic,
//                      one clock behind grant
module seg_disp_arbiter
  import seg_pkg::*;
  #(parameter int N_REQ    = 3,
    parameter int HOLD_CYC = 50_000_000,
    parameter int GAP_CYC  = 2_500_000)
  (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ*POINT_W-1:0]   req_point,
  input  logic [N_REQ-1:0]           req_sign,
  output logic [N_REQ-1:0]           grant,
  output logic [DATA_W-1:0]          data,
  output logic [POINT_W-1:0]         point,
  output logic                       seg_en,
  output logic                       sign
  );

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(max2(HOLD_CYC, GAP_CYC) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

  arb_state_e         state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic [DATA_W-1:0]  data_q;
  logic [POINT_W-1:0] point_q;
  logic               sign_q;
  logic               seg_en_q;

  logic [N_REQ-1:0]   pick_win;
  logic               pick_vld;
  logic [PTR_W-1:0]   pick_idx;

  logic               owner_req;
  logic               others_req;
  logic               leave;
  logic               take;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .vld_o (pick_vld)
  );

  // One-hot winner back to an index for the last-owner pointer.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_win[i]) pick_idx = PTR_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    leave      = 1'b0;
    take       = 1'b0;
    owner_req  = |(req & grant_q);
    others_req = |(req & ~grant_q);

    case (state_q)
      IDLE: begin
        if (pick_vld) take = 1'b1;
      end
      HOLD: begin
        // The last dwell cycle already behaves like SHARE so the grant
        // lasts exactly HOLD_CYC cycles when someone else is waiting.
        if (!owner_req || (cnt_q == HOLD_LAST && others_req)) begin
          leave = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = SHARE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHARE: begin
        // Counter stays saturated at HOLD_LAST here.
        if (!owner_req || others_req) leave = 1'b1;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          // Winner chosen from the requests present now, not at GAP entry.
          if (pick_vld) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (leave) begin
      grant_d = '0;
      cnt_d   = '0;
      if (!others_req)       state_d = IDLE;
      else if (GAP_CYC == 0) take    = 1'b1;
      else                   state_d = GAP;
    end

    if (take) begin
      state_d = HOLD;
      grant_d = pick_win;
      ptr_d   = pick_idx;
      cnt_d   = '0;
    end
  end

  // Live content of the current owner; all-zero when nobody owns.
  logic [DATA_W-1:0]  mux_data;
  logic [POINT_W-1:0] mux_point;
  logic               mux_sign;

  always_comb begin
    mux_data  = '0;
    mux_point = '0;
    mux_sign  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        mux_data  = mux_data  | req_data[i*DATA_W +: DATA_W];
        mux_point = mux_point | req_point[i*POINT_W +: POINT_W];
        mux_sign  = mux_sign  | req_sign[i];
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      cnt_q    <= '0;
      ptr_q    <= PTR_W'(N_REQ - 1);
      data_q   <= '0;
      point_q  <= '0;
      sign_q   <= 1'b0;
      seg_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      data_q   <= mux_data;
      point_q  <= mux_point;
      sign_q   <= mux_sign;
      seg_en_q <= |grant_q;
    end
  end

  assign grant  = grant_q;
  assign data   = data_q;
  assign point  = point_q;
  assign sign   = sign_q;
  assign seg_en = seg_en_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
module tb_seg_disp_arbiter;

  localparam int N    = 3;
  localparam int HOLD = 8;
  localparam int GAPC = 2;

  logic          sys_clk;
  logic          sys_rst;
  logic [N-1:0]  req;
  logic [59:0]   req_data;
  logic [17:0]   req_point;
  logic [N-1:0]  req_sign;
  logic [N-1:0]  grant;
  logic [19:0]   data;
  logic [5:0]    point;
  logic          seg_en;
  logic          sign;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = none), cycles already granted,
  // remaining blank cycles, last owner, and the expected output bundle.
  int          m_owner;
  int          m_held;
  int          m_gap;
  int          m_last;
  logic [19:0] m_data;
  logic [5:0]  m_point;
  logic        m_sign;
  logic        m_en;

  seg_disp_arbiter #(.N_REQ(N), .HOLD_CYC(HOLD), .GAP_CYC(GAPC)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req       (req),
    .req_data  (req_data),
    .req_point (req_point),
    .req_sign  (req_sign),
    .grant     (grant),
    .data      (data),
    .point     (point),
    .seg_en    (seg_en),
    .sign      (sign)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_gap   = 0;
    m_last  = N - 1;
    m_data  = '0;
    m_point = '0;
    m_sign  = 1'b0;
    m_en    = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs present now.
  task automatic model_step();
    int  held;
    bit  own;
    bit  oth;
    if (m_owner >= 0) begin
      m_data  = req_data[m_owner*20 +: 20];
      m_point = req_point[m_owner*6 +: 6];
      m_sign  = req_sign[m_owner];
      m_en    = 1'b1;
    end else begin
      m_data  = '0;
      m_point = '0;
      m_sign  = 1'b0;
      m_en    = 1'b0;
    end
    if (m_owner >= 0) begin
      held = m_held + 1;
      own  = req[m_owner];
      oth  = 1'b0;
      for (int i = 0; i < N; i++) if (i != m_owner && req[i]) oth = 1'b1;
      if (!own || (held >= HOLD && oth)) begin
        m_owner = -1;
        m_gap   = oth ? GAPC : 0;
      end else begin
        m_held = held;
      end
    end else if (m_gap > 1) begin
      m_gap--;
    end else begin
      m_gap = 0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_last  = c;
          m_held  = 0;
        end
      end
    end
  endtask

  function automatic logic [2:0] m_grant();
    logic [2:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".grant"},  32'(grant),  32'(m_grant()));
    check({tag, ".data"},   32'(data),   32'(m_data));
    check({tag, ".point"},  32'(point),  32'(m_point));
    check({tag, ".sign"},   32'(sign),   32'(m_sign));
    check({tag, ".seg_en"}, 32'(seg_en), 32'(m_en));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge sys_clk);
    #1;
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".grant"},  32'(grant),  32'd0);
    check({tag, ".data"},   32'(data),   32'd0);
    check({tag, ".point"},  32'(point),  32'd0);
    check({tag, ".sign"},   32'(sign),   32'd0);
    check({tag, ".seg_en"}, 32'(seg_en), 32'd0);
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic pulse_reset(input string tag);
    #2;
    sys_rst = 1'b1;
    #1;
    check_zero({tag, ".async"});
    model_reset();
    @(posedge sys_clk);
    #1;
    check_zero({tag, ".held"});
    sys_rst = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_g;
    sys_rst   = 1'b0;
    req       = 3'b011;
    req_data  = {20'hC0FFE, 20'hABCDE, 20'h13579};
    req_point = {6'b110000, 6'b001100, 6'b000011};
    req_sign  = 3'b101;
    model_reset();

    // Reset release with two requesters: requester 0 first.
    pulse_reset("rst0");
    step("first_grant");
    check("first_grant.onehot", 32'(grant), 32'h1);
    step("first_data");
    check("first_data.val", 32'(data), 32'h13579);
    check("first_data.en", 32'(seg_en), 32'h1);

    // All three requesting: full rotation with gaps and wrap.
    pulse_reset("rst1");
    req = 3'b111;
    for (int k = 0; k <= 30; k++) begin
      step("rotate");
      exp_g = '0;
      if ((k % 10) < 8) exp_g[(k / 10) % 3] = 1'b1;
      check("rotate.seq", 32'(grant), 32'(exp_g));
    end

    // Owner drops after 3 dwell cycles; requester 1 idle, 2 waiting.
    pulse_reset("rst2");
    req = 3'b101;
    step("drop.a");
    step("drop.b");
    step("drop.c");
    check("drop.owner", 32'(grant), 32'h1);
    req = 3'b100;
    step("drop.gap1");
    check("drop.gap1.g", 32'(grant), 32'h0);
    step("drop.gap2");
    check("drop.gap2.g", 32'(grant), 32'h0);
    check("drop.gap2.en", 32'(seg_en), 32'h0);
    step("drop.next");
    check("drop.next.g", 32'(grant), 32'h4);

    // Lone requester keeps the display without blanking.
    pulse_reset("rst3");
    req = 3'b010;
    step("solo.first");
    for (int k = 0; k < 40; k++) begin
      step("solo");
      check("solo.g", 32'(grant), 32'h2);
      check("solo.en", 32'(seg_en), 32'h1);
    end

    // Owner content changes mid-dwell.
    pulse_reset("rst4");
    req = 3'b001;
    req_data[19:0] = 20'h12345;
    step("live.a");
    step("live.b");
    check("live.before", 32'(data), 32'h12345);
    req_data[19:0] = 20'h00999;
    step("live.c");
    check("live.after", 32'(data), 32'h00999);

    // Reset during GAP, then during HOLD; requester 0 wins again each time.
    pulse_reset("rst5");
    req = 3'b111;
    for (int k = 0; k < 9; k++) step("pre_gap");
    check("pre_gap.g", 32'(grant), 32'h0);
    pulse_reset("rst_gap");
    step("after_gap_rst");
    check("after_gap_rst.g", 32'(grant), 32'h1);
    for (int k = 0; k < 3; k++) step("pre_hold");
    pulse_reset("rst_hold");
    step("after_hold_rst");
    check("after_hold_rst.g", 32'(grant), 32'h1);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        req_data  = {20'($urandom), 20'($urandom), 20'($urandom)};
        req_point = 18'($urandom);
        req_sign  = 3'($urandom);
      end
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
